led_matrix_scanner: RTL and testbench
=====================================

LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

Interface
REQ-001 SHALL have parameter N, default 5, meaning the square grid size, legal range 1..8.
REQ-002 SHALL have parameter DWELL, default 4, meaning the number of drive cycles per column, legal value >= 1.
REQ-003 SHALL have parameter BLANK, default 1, meaning the number of blanking cycles after each column, legal value >= 0.
REQ-004 SHALL have parameter ROW_ACTIVE_LOW, default 0, where 1 inverts the row polarity.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port ena  input  1  scan enable.
REQ-008 SHALL have port cells  input  N*N  Conway grid; bit b*N+a = row a, column b.
REQ-009 SHALL have port rows  output  N  row drive for the active column, registered.
REQ-010 SHALL have port cols  output  N  one-hot column select (active-high), registered.
REQ-011 SHALL have port col_idx  output  $clog2(N)+1  index of the current column.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at the end of each frame.
REQ-013 SHALL report an error from an initial block when any parameter is out of range.

Function
REQ-014 SHALL use a three-state FSM: S_IDLE, S_DRIVE, S_BLANK.
REQ-015 In S_IDLE, ena=1 SHALL cause the following, then S_DRIVE next cycle:
- cells copied into a frame buffer;
- col_idx=0, timer=0.
REQ-016 In S_DRIVE:
- cols SHALL equal 1<<col_idx.
- rows[a] SHALL equal buffer[col_idx*N+a], inverted when ROW_ACTIVE_LOW=1.
REQ-017 S_DRIVE SHALL last exactly DWELL cycles, then go to S_BLANK; when BLANK=0, it SHALL instead advance the column directly.
REQ-018 S_BLANK SHALL last exactly BLANK cycles, then advance the column; cols=0 and rows are inactive during it.
REQ-019 A column advance with col_idx<N-1 SHALL increment col_idx and enter S_DRIVE.
REQ-020 A column advance with col_idx=N-1 (frame end) SHALL:
- pulse frame_done for one cycle;
- wrap col_idx to 0;
- reload the buffer from cells on the same edge.
REQ-021 At frame end, the next state SHALL be S_DRIVE if ena=1, else S_IDLE.
REQ-022 Frame length SHALL be exactly N*(DWELL+BLANK) cycles.
REQ-023 Changes to cells mid-frame SHALL NOT affect the displayed output until the next buffer load.
REQ-024 Deasserting ena mid-frame SHALL let the current frame complete; it SHALL NOT truncate it.
REQ-025 The timer SHALL be sized $clog2(max(DWELL,BLANK)+1) bits and SHALL never wrap within a state.
REQ-026 "Inactive" SHALL mean cols=0 and rows=0, or rows all-ones when ROW_ACTIVE_LOW=1.
REQ-027 In S_IDLE, all outputs SHALL be inactive and frame_done=0.

Reset
REQ-028 rst=1 SHALL, on the next edge, regardless of state:
- force S_IDLE;
- set col_idx=0, timer=0, buffer=0, frame_done=0;
- drive rows and cols inactive.
REQ-029 rst SHALL take priority over ena; reset mid-frame SHALL abort the frame with no frame_done pulse.

Structure
REQ-030 Package led_matrix_pkg SHALL hold the state enum typedef (S_IDLE, S_DRIVE, S_BLANK).
REQ-031 A sub-module col_onehot_decoder SHALL generate cols from col_idx, with an enable input and parameter N.
REQ-032 Total implementation SHALL stay within 120-400 lines of RTL.

Verification (N=5, DWELL=4, BLANK=1 unless stated)
REQ-033 Hold rst=1 for 2 cycles -> rows=0, cols=0, col_idx=0, frame_done=0.
REQ-034 Set cells=25'h1000001 and ena=1 -> expect:
- cols=00001, rows=00001 for 4 cycles;
- cols=0 for 1 cycle;
- columns 1-3 with rows=0;
- cols=10000, rows=10000;
- a single frame_done pulse 25 cycles after the first drive.
REQ-035 Change cells to all-ones during column 2 -> columns 2-4 still show the old data; the next frame shows rows=11111.
REQ-036 Drop ena during column 1 -> columns 2-4 complete, frame_done pulses, then S_IDLE with outputs inactive.
REQ-037 Assert rst during column 3 -> outputs inactive next cycle, no frame_done; after release with ena=1, restart at col_idx=0.
REQ-038 With ROW_ACTIVE_LOW=1 and BLANK=0 -> idle rows=11111; columns are back-to-back with no blank cycle; frame is 20 cycles long.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared types for the LED matrix column scanner.
// Holds the scan FSM state encoding and a small integer helper.
package led_matrix_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/col_onehot_decoder.sv
// Column index to one-hot active-high column select.
// The output is all zeros whenever en is low.
module col_onehot_decoder #(
  parameter int N = 5
) (
  input  logic                 en,
  input  logic [$clog2(N):0]   idx,
  output logic [N-1:0]         onehot
);

  localparam int CW = $clog2(N) + 1;

  // One-hot decode of idx, gated by en
  always_comb begin
    onehot = {N{1'b0}};
    if (en) begin
      for (int i = 0; i < N; i++) begin
        onehot[i] = (idx == CW'(i));
      end
    end else begin
      onehot = {N{1'b0}};
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Column-multiplexed LED matrix scanner: latches a frame of cells, then drives
// each column for DWELL cycles followed by BLANK dark cycles.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int N              = 5,
  parameter int DWELL          = 4,
  parameter int BLANK          = 1,
  parameter int ROW_ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [N*N-1:0]       cells,
  output logic [N-1:0]         rows,
  output logic [N-1:0]         cols,
  output logic [$clog2(N):0]   col_idx,
  output logic                 frame_done
);

  localparam int CW = $clog2(N) + 1;
  localparam int TW = $clog2(max2(DWELL, BLANK) + 1);
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK > 0) ? (BLANK - 1) : 0);
  localparam logic [CW-1:0] COL_LAST   = CW'(N - 1);
  localparam logic [N-1:0]  ROW_IDLE   = (ROW_ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

  initial begin
    if (N < 1 || N > 8) $error("led_matrix_scanner: N=%0d outside 1..8", N);
    if (DWELL < 1) $error("led_matrix_scanner: DWELL=%0d must be >= 1", DWELL);
    if (BLANK < 0) $error("led_matrix_scanner: BLANK=%0d must be >= 0", BLANK);
    if (ROW_ACTIVE_LOW != 0 && ROW_ACTIVE_LOW != 1)
      $error("led_matrix_scanner: ROW_ACTIVE_LOW=%0d must be 0 or 1", ROW_ACTIVE_LOW);
  end

  state_t          state_r, state_s;
  logic [CW-1:0]   col_r, col_s;
  logic [TW-1:0]   timer_r, timer_s;
  logic [N*N-1:0]  buf_r, buf_s;
  logic [N-1:0]    rows_r, rows_s;
  logic [N-1:0]    cols_r, cols_s;
  logic [N-1:0]    col_bits_s;
  logic            fd_r, fd_s;
  logic            adv_s;
  logic            drive_s;

  // Next-state logic; outputs are derived from the next state so they line up with it
  always_comb begin
    state_s = state_r;
    col_s   = col_r;
    timer_s = timer_r;
    buf_s   = buf_r;
    fd_s    = 1'b0;
    adv_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (ena) begin
          buf_s   = cells;
          col_s   = {CW{1'b0}};
          timer_s = {TW{1'b0}};
          state_s = S_DRIVE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_DRIVE: begin
        if (timer_r == DWELL_LAST) begin
          timer_s = {TW{1'b0}};
          if (BLANK == 0) begin
            adv_s = 1'b1;
          end else begin
            state_s = S_BLANK;
          end
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      S_BLANK: begin
        if (timer_r == BLANK_LAST) begin
          timer_s = {TW{1'b0}};
          adv_s   = 1'b1;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // Column advance; the last column closes the frame and reloads the buffer
    if (adv_s) begin
      if (col_r == COL_LAST) begin
        fd_s    = 1'b1;
        col_s   = {CW{1'b0}};
        buf_s   = cells;
        state_s = ena ? S_DRIVE : S_IDLE;
      end else begin
        col_s   = col_r + CW'(1);
        state_s = S_DRIVE;
      end
    end else begin
      fd_s = 1'b0;
    end
  end

  assign drive_s = (state_s == S_DRIVE);

  // Select the buffered column that will be driven next cycle
  always_comb begin
    col_bits_s = {N{1'b0}};
    for (int b = 0; b < N; b++) begin
      if (col_s == CW'(b)) begin
        col_bits_s = buf_s[b*N +: N];
      end else begin
        col_bits_s = col_bits_s;
      end
    end
    if (drive_s) begin
      rows_s = col_bits_s ^ ROW_IDLE;
    end else begin
      rows_s = ROW_IDLE;
    end
  end

  col_onehot_decoder #(.N(N)) u_dec (
    .en     (drive_s),
    .idx    (col_s),
    .onehot (cols_s)
  );

  // State, frame buffer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      col_r   <= {CW{1'b0}};
      timer_r <= {TW{1'b0}};
      buf_r   <= {(N*N){1'b0}};
      rows_r  <= ROW_IDLE;
      cols_r  <= {N{1'b0}};
      fd_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      col_r   <= col_s;
      timer_r <= timer_s;
      buf_r   <= buf_s;
      rows_r  <= rows_s;
      cols_r  <= cols_s;
      fd_r    <= fd_s;
    end
  end

  assign rows       = rows_r;
  assign cols       = cols_r;
  assign col_idx    = col_r;
  assign frame_done = fd_r;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: a default instance (BLANK=1, active-high rows) and an
// active-low, no-blank instance share stimulus; a frame-position model checks both.
module tb_led_matrix_scanner;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic [24:0] cells = 25'd0;
  logic [4:0]  rows_a, cols_a, rows_b, cols_b;
  logic [3:0]  idx_a, idx_b;
  logic        fd_a, fd_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_matrix_scanner #(.N(5), .DWELL(4), .BLANK(1), .ROW_ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .cells(cells),
    .rows(rows_a), .cols(cols_a), .col_idx(idx_a), .frame_done(fd_a)
  );

  led_matrix_scanner #(.N(5), .DWELL(4), .BLANK(0), .ROW_ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .cells(cells),
    .rows(rows_b), .cols(cols_b), .col_idx(idx_b), .frame_done(fd_b)
  );

  // Reference model: position within the frame plus a latched copy of the grid
  int          m_dw  [2] = '{4, 4};
  int          m_bl  [2] = '{1, 0};
  int          m_pol [2] = '{0, 1};
  bit          m_act [2];
  int          m_pos [2];
  logic [24:0] m_buf [2];
  bit          m_fd  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input int k);
    if (rst) begin
      m_act[k] = 1'b0; m_pos[k] = 0; m_buf[k] = 25'd0; m_fd[k] = 1'b0;
    end else if (!m_act[k]) begin
      m_fd[k] = 1'b0;
      if (ena) begin
        m_act[k] = 1'b1; m_pos[k] = 0; m_buf[k] = cells;
      end
    end else begin
      m_fd[k]  = 1'b0;
      m_pos[k] = m_pos[k] + 1;
      if (m_pos[k] == N * (m_dw[k] + m_bl[k])) begin
        m_fd[k] = 1'b1; m_pos[k] = 0; m_buf[k] = cells; m_act[k] = ena;
      end
    end
  endtask

  task automatic model_check(input int k, input logic [4:0] r, input logic [4:0] c,
                             input logic [3:0] i, input logic f);
    int          per, col;
    bit          drive;
    logic [4:0]  polm, exp_c, exp_r;
    logic [24:0] sh;
    per   = m_dw[k] + m_bl[k];
    col   = m_act[k] ? (m_pos[k] / per) : 0;
    drive = m_act[k] && ((m_pos[k] % per) < m_dw[k]);
    polm  = (m_pol[k] != 0) ? 5'b11111 : 5'b00000;
    sh    = m_buf[k] >> (col * N);
    exp_c = drive ? 5'(1 << col) : 5'b00000;
    exp_r = drive ? (sh[4:0] ^ polm) : polm;
    chk($sformatf("model_rows%0d", k), 32'(r), 32'(exp_r));
    chk($sformatf("model_cols%0d", k), 32'(c), 32'(exp_c));
    chk($sformatf("model_idx%0d", k), 32'(i), 32'(col));
    chk($sformatf("model_fd%0d", k), 32'(f), 32'(m_fd[k]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    model_check(0, rows_a, cols_a, idx_a, fd_a);
    model_check(1, rows_b, cols_b, idx_b, fd_b);
  endtask

  task automatic wait_col(input int target, input int budget);
    int n = 0;
    while (idx_a != 4'(target) && n < budget) begin
      step();
      n++;
    end
    chk($sformatf("wait_col%0d", target), 32'(idx_a), 32'(target));
  endtask

  // Steps until instance k pulses frame_done; n is the number of steps taken
  task automatic wait_fd(input int k, input int budget, output int n);
    logic f;
    n = 0;
    f = 1'b0;
    while (!f && n < budget) begin
      step();
      n++;
      f = (k == 0) ? fd_a : fd_b;
    end
    chk($sformatf("wait_fd%0d", k), 32'(f), 32'd1);
  endtask

  typedef struct {
    logic        rst;
    logic        ena;
    logic [24:0] cells;
    int          reps;
    logic [4:0]  cols;
    logic [4:0]  rows;
    logic        fd;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int n;
    logic [24:0] h;
    h = 25'h1000001;
    tbl.push_back('{1'b1, 1'b0, 25'd0, 2, 5'b00000, 5'b00000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, h, 4, 5'b00001, 5'b00001, 1'b0});
    tbl.push_back('{1'b0, 1'b1, h, 1, 5'b00000, 5'b00000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, h, 4, 5'b00010, 5'b00000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, h, 1, 5'b00000, 5'b00000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, h, 4, 5'b00100, 5'b00000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, h, 1, 5'b00000, 5'b00000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, h, 4, 5'b01000, 5'b00000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, h, 1, 5'b00000, 5'b00000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, h, 4, 5'b10000, 5'b10000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, h, 1, 5'b00000, 5'b00000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, h, 1, 5'b00001, 5'b00001, 1'b1});
    tbl.push_back('{1'b0, 1'b1, h, 3, 5'b00001, 5'b00001, 1'b0});

    foreach (tbl[v]) begin
      rst   = tbl[v].rst;
      ena   = tbl[v].ena;
      cells = tbl[v].cells;
      for (int r = 0; r < tbl[v].reps; r++) begin
        step();
        chk($sformatf("tbl%0d_cols", v), 32'(cols_a), 32'(tbl[v].cols));
        chk($sformatf("tbl%0d_rows", v), 32'(rows_a), 32'(tbl[v].rows));
        chk($sformatf("tbl%0d_fd", v), 32'(fd_a), 32'(tbl[v].fd));
      end
    end

    // Mid-frame cell change only shows up after the next buffer load
    wait_col(2, 30);
    cells = 25'h1ffffff;
    wait_fd(0, 30, n);
    chk("new_frame_rows", 32'(rows_a), 32'h1f);
    wait_fd(0, 40, n);
    chk("frame_len_a", 32'(n), 32'd25);

    // Dropping ena mid-frame lets the frame finish, then idles
    wait_col(1, 30);
    ena = 1'b0;
    wait_fd(0, 40, n);
    chk("drop_ena_cols", 32'(cols_a), 32'd0);
    chk("drop_ena_rows", 32'(rows_a), 32'd0);
    for (int i = 0; i < 25; i++) step();
    chk("idle_idx_a", 32'(idx_a), 32'd0);
    chk("idle_rows_b", 32'(rows_b), 32'h1f);
    chk("idle_cols_b", 32'(cols_b), 32'd0);

    // Reset mid-frame aborts without a frame_done pulse
    ena = 1'b1;
    cells = 25'h0a5a5a5;
    wait_col(3, 30);
    rst = 1'b1;
    step();
    chk("rst_cols", 32'(cols_a), 32'd0);
    chk("rst_rows", 32'(rows_a), 32'd0);
    chk("rst_fd", 32'(fd_a), 32'd0);
    chk("rst_rows_b", 32'(rows_b), 32'h1f);
    rst = 1'b0;
    step();
    chk("restart_idx", 32'(idx_a), 32'd0);
    chk("restart_cols", 32'(cols_a), 32'd1);

    // Back-to-back columns in the no-blank instance
    wait_fd(1, 40, n);
    wait_fd(1, 40, n);
    chk("frame_len_b", 32'(n), 32'd20);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cells = 25'($urandom);
      ena   = ($urandom_range(0, 7) != 0);
      rst   = ($urandom_range(0, 79) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
